// File: rtl/ads131_pkg.sv
// ads131_pkg: shared definitions for the ADS131A0x power-up / streaming sequencer.
//   - 16-bit command words (left-justified into the SPI word by the sequencer)
//   - FSM state encoding (also exported on the 4-bit debug port)
//   - register configuration ROM and the init step table built on top of it
package ads131_pkg;

  localparam logic [15:0] CMD_NULL   = 16'h0000;
  localparam logic [15:0] CMD_UNLOCK = 16'h0655;
  localparam logic [15:0] CMD_WAKEUP = 16'h0033;
  localparam logic [15:0] OP_WREG    = 16'h4000;
  localparam logic [15:0] OP_RREG    = 16'h2000;
  // The ADC acknowledges a WREG by echoing it in RREG format.
  localparam logic [15:0] RSP_WREG   = OP_RREG;

  localparam int unsigned CFG_ENTRIES = 5;

  // Init steps: 0 = UNLOCK, 1..5 = WREG from the ROM, 6 = WAKEUP, 7 = NULL (verify).
  localparam logic [2:0] STEP_UNLOCK = 3'd0;
  localparam logic [2:0] STEP_WAKEUP = 3'd6;
  localparam logic [2:0] STEP_VERIFY = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_RESET_LOW    = 4'd1,
    ST_STARTUP_WAIT = 4'd2,
    ST_SEND_UNLOCK  = 4'd3,
    ST_SEND_CFG     = 4'd4,
    ST_SEND_WAKEUP  = 4'd5,
    ST_VERIFY       = 4'd6,
    ST_STREAM_IDLE  = 4'd7,
    ST_STREAM_READ  = 4'd8,
    ST_ERROR        = 4'd9
  } state_t;

  // {addr, data} of each configuration register write, in issue order.
  function automatic logic [15:0] cfg_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'h0B60;
      3'd1:    return 16'h0C3C;
      3'd2:    return 16'h0D08;
      3'd3:    return 16'h0E86;
      3'd4:    return 16'h0F0F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] step_cmd(input logic [2:0] step);
    case (step)
      STEP_UNLOCK:                      return CMD_UNLOCK;
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5:     return OP_WREG | cfg_entry(step - 3'd1);
      STEP_WAKEUP:                      return CMD_WAKEUP;
      default:                          return CMD_NULL;
    endcase
  endfunction

  function automatic logic [15:0] step_rsp(input logic [2:0] step);
    case (step)
      STEP_UNLOCK:                      return CMD_UNLOCK;
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5:     return RSP_WREG | cfg_entry(step - 3'd1);
      STEP_WAKEUP:                      return CMD_WAKEUP;
      default:                          return CMD_NULL;
    endcase
  endfunction

  function automatic state_t step_state(input logic [2:0] step);
    case (step)
      STEP_UNLOCK:                      return ST_SEND_UNLOCK;
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5:     return ST_SEND_CFG;
      STEP_WAKEUP:                      return ST_SEND_WAKEUP;
      default:                          return ST_VERIFY;
    endcase
  endfunction

endpackage

// File: rtl/ads131_drdy_sync.sv
// ads131_drdy_sync: brings the asynchronous DRDY pin into the system clock domain
// and produces a one-cycle pulse for each falling edge.
//   system_clock  in   system clock
//   reset_n       in   synchronous active-low reset
//   adc_drdy_n    in   raw DRDY pin (active-low, asynchronous)
//   drdy_fall     out  registered one-cycle pulse, 3 cycles after the pin falls
module ads131_drdy_sync (
  input  logic system_clock,
  input  logic reset_n,
  input  logic adc_drdy_n,
  output logic drdy_fall
);

  logic sync1, sync2, sync_prev;

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      drdy_fall <= 1'b0;
    end else begin
      sync1     <= adc_drdy_n;
      sync2     <= sync1;
      sync_prev <= sync2;
      drdy_fall <= sync_prev & ~sync2;
    end
  end

endmodule

// File: rtl/ads131_sequencer.sv
// ads131_sequencer: takes the ADS131A0x from power-up to continuous conversion,
// then turns each DRDY falling edge into one frame read.
//   system_clock, reset_n        clock, synchronous active-low reset
//   start_init                   level; leaves IDLE on the first high cycle
//   adc_drdy_n                   raw DRDY pin
//   ADC_RESET                    ADC reset pin (active-low)
//   spi_start/spi_tx_word/
//   spi_frame_last               word launch towards the SPI word engine
//   spi_done/spi_rx_word         word completion from the SPI word engine
//   sample_data/sample_status/
//   sample_valid                 latest frame (ch0 in LSBs) and its strobe
//   init_done/error/overrun      sticky flags
//   state                        debug copy of the FSM state
module ads131_sequencer
  import ads131_pkg::*;
#(
  parameter int unsigned RESET_LOW_CYCLES    = 250000,
  parameter int unsigned STARTUP_WAIT_CYCLES = 1000000,
  parameter int unsigned NUM_CH              = 4,
  parameter int unsigned WORD_BITS           = 24,
  parameter int unsigned MAX_RETRY           = 3
) (
  input  logic                          system_clock,
  input  logic                          reset_n,
  input  logic                          start_init,
  input  logic                          adc_drdy_n,
  output logic                          ADC_RESET,
  output logic                          spi_start,
  output logic [WORD_BITS-1:0]          spi_tx_word,
  output logic                          spi_frame_last,
  input  logic                          spi_done,
  input  logic [WORD_BITS-1:0]          spi_rx_word,
  output logic [NUM_CH*WORD_BITS-1:0]   sample_data,
  output logic [WORD_BITS-1:0]          sample_status,
  output logic                          sample_valid,
  output logic                          init_done,
  output logic                          error,
  output logic                          overrun,
  output logic [3:0]                    state
);

  localparam int unsigned WCW = (NUM_CH < 1) ? 1 : $clog2(NUM_CH + 1);
  localparam int unsigned RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_CH);
  localparam int unsigned FW = (NUM_CH + 1) * WORD_BITS;

  state_t                      st_q;
  logic [31:0]                 cyc_cnt;
  logic [WCW-1:0]              word_cnt;
  logic [WCW-1:0]              next_word;
  logic                        busy;        // a word is outstanding at the engine
  logic [1:0]                  gap_cnt;     // inter-frame CS-high gap
  logic [2:0]                  step_q;      // init step being sent this frame
  logic [2:0]                  prev_step;   // step whose response arrives this frame
  logic                        prev_valid;
  logic [RCW-1:0]              retry_cnt;
  logic                        drdy_pend;
  logic                        drdy_fall;
  logic [NUM_CH*WORD_BITS-1:0] rx_shift;    // words 0..NUM_CH-1, word0 in LSBs
  logic [FW-1:0]               frame_cat;
  logic                        done_ok;
  logic                        frame_end;
  logic [15:0]                 rsp_word;
  logic                        rsp_match;

  function automatic logic [WORD_BITS-1:0] cmd_word(input logic [15:0] cmd);
    logic [WORD_BITS-1:0] w;
    w = '0;
    w[WORD_BITS-1 -: 16] = cmd;
    return w;
  endfunction

  ads131_drdy_sync u_drdy_sync (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .adc_drdy_n   (adc_drdy_n),
    .drdy_fall    (drdy_fall)
  );

  always_comb begin
    done_ok   = spi_done && busy;
    frame_end = done_ok && (word_cnt == LAST_WORD);
    next_word = word_cnt + 1'b1;
    frame_cat = {spi_rx_word, rx_shift};
    rsp_word  = frame_cat[WORD_BITS-1 -: 16];
    rsp_match = (rsp_word == step_rsp(prev_step));
  end

  assign state = st_q;

  always_ff @(posedge system_clock) begin
    if (!reset_n) begin
      st_q           <= ST_IDLE;
      ADC_RESET      <= 1'b1;
      spi_start      <= 1'b0;
      spi_tx_word    <= '0;
      spi_frame_last <= 1'b0;
      sample_data    <= '0;
      sample_status  <= '0;
      sample_valid   <= 1'b0;
      init_done      <= 1'b0;
      error          <= 1'b0;
      overrun        <= 1'b0;
      cyc_cnt        <= '0;
      word_cnt       <= '0;
      busy           <= 1'b0;
      gap_cnt        <= '0;
      step_q         <= STEP_UNLOCK;
      prev_step      <= STEP_UNLOCK;
      prev_valid     <= 1'b0;
      retry_cnt      <= '0;
      drdy_pend      <= 1'b0;
      rx_shift       <= '0;
    end else begin
      spi_start    <= 1'b0;
      sample_valid <= 1'b0;
      if (gap_cnt != 2'd0) gap_cnt <= gap_cnt - 2'd1;

      // Word completion: shift in the word and launch the next one of the frame.
      if (done_ok) begin
        busy     <= 1'b0;
        rx_shift <= frame_cat[FW-1:WORD_BITS];
        if (!frame_end) begin
          word_cnt       <= next_word;
          spi_start      <= 1'b1;
          busy           <= 1'b1;
          spi_tx_word    <= '0;
          spi_frame_last <= (next_word == LAST_WORD);
        end
      end

      case (st_q)
        ST_IDLE: begin
          if (start_init) begin
            st_q      <= ST_RESET_LOW;
            ADC_RESET <= 1'b0;
            cyc_cnt   <= '0;
          end
        end

        ST_RESET_LOW: begin
          if (cyc_cnt == 32'(RESET_LOW_CYCLES - 1)) begin
            st_q      <= ST_STARTUP_WAIT;
            ADC_RESET <= 1'b1;
            cyc_cnt   <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end

        ST_STARTUP_WAIT: begin
          if (cyc_cnt == 32'(STARTUP_WAIT_CYCLES - 1)) begin
            st_q           <= ST_SEND_UNLOCK;
            step_q         <= STEP_UNLOCK;
            prev_valid     <= 1'b0;
            retry_cnt      <= '0;
            word_cnt       <= '0;
            spi_start      <= 1'b1;
            busy           <= 1'b1;
            spi_tx_word    <= cmd_word(CMD_UNLOCK);
            spi_frame_last <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end

        // Each frame carries a new command and returns the response to the
        // previous one. After a mismatch the failed command is resent, and
        // the frame following the resend carries a stale response, so that
        // one check is skipped (prev_valid low).
        ST_SEND_UNLOCK, ST_SEND_CFG, ST_SEND_WAKEUP, ST_VERIFY: begin
          if (frame_end) begin
            if (prev_valid && !rsp_match) begin
              if (retry_cnt == RCW'(MAX_RETRY)) begin
                st_q  <= ST_ERROR;
                error <= 1'b1;
              end else begin
                retry_cnt  <= retry_cnt + 1'b1;
                step_q     <= prev_step;
                st_q       <= step_state(prev_step);
                prev_valid <= 1'b0;
                gap_cnt    <= 2'd2;
              end
            end else if (prev_valid && prev_step == STEP_WAKEUP) begin
              init_done <= 1'b1;
              st_q      <= ST_STREAM_IDLE;
              gap_cnt   <= 2'd2;
            end else begin
              if (prev_valid) retry_cnt <= '0;
              prev_step  <= step_q;
              prev_valid <= 1'b1;
              step_q     <= step_q + 3'd1;
              st_q       <= step_state(step_q + 3'd1);
              gap_cnt    <= 2'd2;
            end
          end else if (gap_cnt == 2'd1 && !busy) begin
            word_cnt       <= '0;
            spi_start      <= 1'b1;
            busy           <= 1'b1;
            spi_tx_word    <= cmd_word(step_cmd(step_q));
            spi_frame_last <= 1'b0;
          end
        end

        ST_STREAM_IDLE: begin
          if (drdy_fall) drdy_pend <= 1'b1;
          if ((drdy_fall || drdy_pend) && gap_cnt <= 2'd1 && !busy) begin
            drdy_pend      <= 1'b0;
            st_q           <= ST_STREAM_READ;
            word_cnt       <= '0;
            spi_start      <= 1'b1;
            busy           <= 1'b1;
            spi_tx_word    <= cmd_word(CMD_NULL);
            spi_frame_last <= 1'b0;
          end
        end

        ST_STREAM_READ: begin
          if (drdy_fall) overrun <= 1'b1;
          if (frame_end) begin
            sample_data   <= frame_cat[FW-1:WORD_BITS];
            sample_status <= frame_cat[WORD_BITS-1:0];
            sample_valid  <= 1'b1;
            st_q          <= ST_STREAM_IDLE;
            gap_cnt       <= 2'd2;
          end
        end

        default: ;  // ST_ERROR: only reset leaves
      endcase
    end
  end

endmodule

// File: tb/tb_ads131_sequencer.sv
module tb_ads131_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_init;
  logic        adc_drdy_n;
  logic        ADC_RESET;
  logic        spi_start;
  logic [23:0] spi_tx_word;
  logic        spi_frame_last;
  logic        spi_done;
  logic [23:0] spi_rx_word;
  logic [95:0] sample_data;
  logic [23:0] sample_status;
  logic        sample_valid;
  logic        init_done, error, overrun;
  logic [3:0]  state;

  int total = 0;
  int bad   = 0;

  // ADC / SPI engine model state
  int          mode = 0;           // 0 echo, 1 UNLOCK answered with 0, 2 streaming data
  int          wi = 0;             // word index inside the frame
  int          word_total = 0;
  int          fmt_err = 0;
  int          sv_cnt = 0;
  logic [15:0] adc_resp = 16'h0;
  logic [15:0] cur_cmd;
  logic [23:0] tx_w, rx_w;
  logic [15:0] f_cmd[$];

  logic [15:0] exp_seq [8] = '{16'h0655, 16'h4B60, 16'h4C3C, 16'h4D08,
                               16'h4E86, 16'h4F0F, 16'h0033, 16'h0000};

  ads131_sequencer #(
    .RESET_LOW_CYCLES    (10),
    .STARTUP_WAIT_CYCLES (20),
    .NUM_CH              (4),
    .WORD_BITS           (24),
    .MAX_RETRY           (3)
  ) dut (
    .system_clock   (clk),
    .reset_n        (reset_n),
    .start_init     (start_init),
    .adc_drdy_n     (adc_drdy_n),
    .ADC_RESET      (ADC_RESET),
    .spi_start      (spi_start),
    .spi_tx_word    (spi_tx_word),
    .spi_frame_last (spi_frame_last),
    .spi_done       (spi_done),
    .spi_rx_word    (spi_rx_word),
    .sample_data    (sample_data),
    .sample_status  (sample_status),
    .sample_valid   (sample_valid),
    .init_done      (init_done),
    .error          (error),
    .overrun        (overrun),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] next_resp(input logic [15:0] c);
    if (c == 16'h0655)          return (mode == 1) ? 16'h0000 : 16'h0655;
    else if (c == 16'h0033)     return 16'h0033;
    else if (c[15:12] == 4'h4)  return {4'h2, c[11:0]};
    else                        return 16'h2200;
  endfunction

  // SPI engine + ADC model: 3-cycle words, word0 returns the previous command's response.
  initial begin
    spi_done = 1'b0;
    spi_rx_word = '0;
    forever begin
      if (spi_start === 1'b1) begin
        tx_w = spi_tx_word;
        word_total++;
        if (spi_frame_last !== (wi == 4)) fmt_err++;
        if (wi == 0) begin
          cur_cmd = tx_w[23:8];
          f_cmd.push_back(cur_cmd);
          if (tx_w[7:0] != 8'h00) fmt_err++;
        end else if (tx_w != 24'h0) fmt_err++;
        if (mode == 2) rx_w = (wi == 0) ? 24'h220000 : 24'(wi);
        else           rx_w = (wi == 0) ? {adc_resp, 8'h00} : 24'h0;
        repeat (2) @(posedge clk);
        #1;
        spi_done = 1'b1;
        spi_rx_word = rx_w;
        @(posedge clk);
        #1;
        spi_done = 1'b0;
        if (wi == 4) begin
          adc_resp = next_resp(cur_cmd);
          wi = 0;
        end else wi++;
      end else begin
        @(posedge clk);
        #1;
        if (ADC_RESET === 1'b0) begin
          adc_resp = 16'h0;
          wi = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sample_valid === 1'b1) sv_cnt++;
    end
  end

  task automatic clear_log();
    f_cmd.delete();
    word_total = 0;
    fmt_err = 0;
    wi = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_state"}, 96'(state), 96'd0);
    check_val({pfx, "_adc_reset"}, 96'(ADC_RESET), 96'd1);
    check_val({pfx, "_spi_start"}, 96'(spi_start), 96'd0);
    check_val({pfx, "_tx_word"}, 96'(spi_tx_word), 96'd0);
    check_val({pfx, "_frame_last"}, 96'(spi_frame_last), 96'd0);
    check_val({pfx, "_sample_data"}, sample_data, 96'd0);
    check_val({pfx, "_sample_status"}, 96'(sample_status), 96'd0);
    check_val({pfx, "_sample_valid"}, 96'(sample_valid), 96'd0);
    check_val({pfx, "_init_done"}, 96'(init_done), 96'd0);
    check_val({pfx, "_error"}, 96'(error), 96'd0);
    check_val({pfx, "_overrun"}, 96'(overrun), 96'd0);
  endtask

  task automatic pulse_start();
    start_init = 1'b1;
    @(posedge clk);
    #1;
    start_init = 1'b0;
  endtask

  task automatic wait_init_done(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val(tag, 96'(init_done), 96'd1);
  endtask

  initial begin
    int n, low_cnt, rel, sv0, words0, unl, starts;

    reset_n = 1'b0;
    start_init = 1'b0;
    adc_drdy_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    // ---- power-up timing ----
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    start_init = 1'b1;
    n = 0;
    while (ADC_RESET !== 1'b0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    start_init = 1'b0;
    check_val("reset_low_latency", 96'(n), 96'd1);
    low_cnt = 0;
    while (ADC_RESET === 1'b0 && low_cnt < 1000) begin
      low_cnt++;
      @(posedge clk);
      #1;
    end
    check_val("reset_low_cycles", 96'(low_cnt), 96'd10);
    rel = 0;
    while (spi_start !== 1'b1 && rel < 1000) begin
      @(posedge clk);
      #1;
      rel++;
    end
    check_val("startup_wait_cycles", 96'(rel), 96'd20);
    check_val("first_tx_word", 96'(spi_tx_word), 96'h065500);
    check_val("first_state", 96'(state), 96'd3);

    // ---- init sequence with echoing ADC; a DRDY pulse here must be ignored ----
    n = 0;
    while (init_done !== 1'b1 && n < 3000) begin
      if (n == 30) adc_drdy_n = 1'b0;
      if (n == 40) adc_drdy_n = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check_val("init_done", 96'(init_done), 96'd1);
    check_val("init_frames", 96'(f_cmd.size()), 96'd8);
    for (int i = 0; i < 8; i++) check_val($sformatf("init_cmd%0d", i), 96'(f_cmd[i]), 96'(exp_seq[i]));
    check_val("init_words", 96'(word_total), 96'd40);
    check_val("init_format", 96'(fmt_err), 96'd0);
    check_val("init_state", 96'(state), 96'd7);
    check_val("init_error", 96'(error), 96'd0);
    check_val("init_overrun", 96'(overrun), 96'd0);
    check_val("init_no_sample", 96'(sv_cnt), 96'd0);

    // ---- streaming: one DRDY, one sample ----
    mode = 2;
    repeat (5) @(posedge clk);
    #1;
    sv0 = sv_cnt;
    adc_drdy_n = 1'b0;
    n = 0;
    while (sv_cnt == sv0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    adc_drdy_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_val("stream_valid_count", 96'(sv_cnt - sv0), 96'd1);
    check_val("stream_ch0", 96'(sample_data[23:0]), 96'h000001);
    check_val("stream_data", sample_data, 96'h000004_000003_000002_000001);
    check_val("stream_status", 96'(sample_status), 96'h220000);
    check_val("stream_overrun", 96'(overrun), 96'd0);
    check_val("stream_state", 96'(state), 96'd7);

    // ---- overrun: second DRDY mid-frame ----
    sv0 = sv_cnt;
    adc_drdy_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    adc_drdy_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    adc_drdy_n = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check_val("ovr_flag", 96'(overrun), 96'd1);
    check_val("ovr_valid_count", 96'(sv_cnt - sv0), 96'd1);
    adc_drdy_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    adc_drdy_n = 1'b0;
    n = 0;
    while (sv_cnt < sv0 + 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    adc_drdy_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_val("ovr_next_serviced", 96'(sv_cnt - sv0), 96'd2);
    check_val("ovr_next_ch3", 96'(sample_data[95:72]), 96'h000004);
    check_val("ovr_next_status", 96'(sample_status), 96'h220000);

    // ---- UNLOCK never acknowledged: retries then ERROR ----
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mode = 1;
    clear_log();
    pulse_start();
    n = 0;
    while (error !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("err_flag", 96'(error), 96'd1);
    check_val("err_state", 96'(state), 96'd9);
    check_val("err_init_done", 96'(init_done), 96'd0);
    unl = 0;
    foreach (f_cmd[i]) if (f_cmd[i] == 16'h0655) unl++;
    check_val("err_unlock_sends", 96'(unl), 96'd4);
    check_val("err_frames", 96'(f_cmd.size()), 96'd8);
    words0 = word_total;
    repeat (100) @(posedge clk);
    #1;
    check_val("err_no_more_words", 96'(word_total), 96'(words0));
    check_val("err_sticky", 96'(error), 96'd1);

    // ---- reset in the middle of a WREG frame ----
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mode = 0;
    clear_log();
    pulse_start();
    n = 0;
    while (f_cmd.size() < 3 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("mid_reached_wreg", 96'(f_cmd.size()), 96'd3);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    reset_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (spi_start === 1'b1) starts++;
    end
    check_val("mid_no_start", 96'(starts), 96'd0);
    check_val("mid_idle_state", 96'(state), 96'd0);
    clear_log();
    pulse_start();
    wait_init_done("mid_reinit_done");
    check_val("mid_reinit_frames", 96'(f_cmd.size()), 96'd8);
    check_val("mid_reinit_format", 96'(fmt_err), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ads131_sequencer.md
# ads131_sequencer

Controller that takes the ADS131A0x ADC from power-up to continuous conversion and then schedules one frame read per data-ready. It sits between the top level and the SPI word engine: it drives the ADC reset pin, issues the unlock/configure/wakeup command sequence with response checking, and then converts each DRDY falling edge into a frame read that is presented as a parallel sample with a valid strobe. It owns no serial timing; all bit-level SPI work is delegated to the engine through a start/done handshake.

## Interface
- RESET_LOW_CYCLES, 250000, cycles ADC_RESET is held low (5 ms at 50 MHz)
- STARTUP_WAIT_CYCLES, 1000000, cycles waited after reset release before the first frame (20 ms)
- NUM_CH, 4, ADC channels per frame
- WORD_BITS, 24, bits per SPI word; 16-bit commands are left-justified and zero-padded
- MAX_RETRY, 3, retries of a command whose response mismatches
- system_clock  in  1  single clock, 50 MHz; reset is synchronous and active-low
- reset_n  in  1  synchronous active-low reset
- start_init  in  1  level; the sequence leaves IDLE on the first cycle this is high
- adc_drdy_n  in  1  ADC DRDY, asynchronous; 2-flop synchronised internally
- ADC_RESET  out  1  ADC reset pin, active-low
- spi_start  out  1  one-cycle pulse that launches one word
- spi_tx_word  out  WORD_BITS  word to shift out; stable from spi_start until spi_done
- spi_frame_last  out  1  marks the current word as the last one in the frame; engine raises CS after it
- spi_done  in  1  one-cycle pulse at the end of a word
- spi_rx_word  in  WORD_BITS  received word; valid in the spi_done cycle
- sample_data  out  NUM_CH*WORD_BITS  channel words; ch0 is in the LSBs
- sample_status  out  WORD_BITS  word0 (status) of the latest frame
- sample_valid  out  1  one-cycle strobe
- init_done, error, overrun  out  1 each  sticky flags
- state  out  4  debug copy of the current state

## Operation
- Every frame is FRAME_WORDS = NUM_CH+1 words. Word0 carries the command (or NULL 0x0000); the remaining words are zero. The ADC returns the response to the previous frame's command in word0.
- States and transitions:
  - IDLE: move to RESET_LOW when start_init is high.
  - RESET_LOW: ADC_RESET=0 for RESET_LOW_CYCLES cycles.
  - STARTUP_WAIT: ADC_RESET=1 for STARTUP_WAIT_CYCLES cycles.
  - SEND_UNLOCK: send 0x0655.
  - SEND_CFG: send WREG 0x4000|addr<<8|data, one entry of the package ROM per frame.
  - SEND_WAKEUP: send 0x0033.
  - VERIFY: send one NULL frame to collect the final response.
  - STREAM_IDLE: wait for a DRDY falling edge.
  - STREAM_READ: read one frame.
  - ERROR: terminal.
- Response checks, made on word0[WORD_BITS-1 -: 16] of the next frame:
  - UNLOCK expects 0x0655.
  - WREG expects 0x2000|addr<<8|data.
  - WAKEUP expects 0x0033.
- On a mismatch, resend the failed command; the retry count is per command. After MAX_RETRY failed retries: error=1 and the FSM enters ERROR. Only reset leaves ERROR.
- A good WAKEUP response sets init_done=1 and the FSM enters STREAM_IDLE.
- In STREAM, a DRDY falling edge starts a NULL frame. At the last spi_done the FSM latches sample_data and sample_status and pulses sample_valid.
- A DRDY falling edge during STREAM_READ sets overrun. The in-progress frame completes normally; the extra edge is dropped, not queued.
- DRDY edges before STREAM_IDLE are ignored.
- Word counter is 0..NUM_CH with no wrap. spi_frame_last=1 exactly when the counter equals NUM_CH.

## Timing
- Reset values:
  - state=IDLE, ADC_RESET=1.
  - spi_start=0, spi_tx_word=0, spi_frame_last=0.
  - sample_data=0, sample_status=0, sample_valid=0.
  - init_done=0, error=0, overrun=0.
- Reset takes effect on the first system_clock edge with reset_n low. This applies mid-frame too: spi_start is never issued again until the sequence restarts, and a pending spi_done is ignored.
- Word launch: the next spi_start comes 1 cycle after spi_done (back-to-back words within a frame). Between frames there is a 2-cycle gap so CS stays high.
- spi_start is never issued while a word is outstanding. A spi_done with no word outstanding is ignored.
- DRDY: edge detect is 3 cycles after the falling edge (2 sync flops + 1 edge register). spi_start follows on the next cycle.
- Output timing: sample_valid is asserted the cycle after the final spi_done.
- Reset and counter timing: ADC_RESET goes low the cycle after start_init is seen. The cycle counters count exactly their parameter value.

## Structure
- Package ads131_pkg holds:
  - command constants: CMD_NULL, CMD_UNLOCK, CMD_WAKEUP, WREG/RREG opcodes.
  - state encoding.
  - config ROM, 5 entries: 0x0B=0x60, 0x0C=0x3C, 0x0D=0x08, 0x0E=0x86, 0x0F=0x0F.
- One sub-module, ads131_drdy_sync: 2-flop synchroniser plus falling-edge detector.

## Test plan
- Reset then start_init with RESET_LOW_CYCLES=10 and STARTUP_WAIT_CYCLES=20. Required: ADC_RESET low for exactly 10 cycles, the first spi_start 20 cycles after release, and tx word0 = 0x065500.
- ADC model echoing correct responses. Required: the frame sequence UNLOCK, 5 WREGs in ROM order, WAKEUP, NULL, each 5 words with spi_frame_last on word 4; then init_done=1.
- Model returns 0x0000 to UNLOCK every time. Required: UNLOCK is sent 1+3 times, then error=1 and no further spi_start.
- Streaming: DRDY falls and the model returns words 0x220000, 0x000001..0x000004. Required: one sample_valid with sample_data[23:0]=0x000001 and sample_status=0x220000.
- A second DRDY falls mid-frame. Required: overrun=1, exactly one sample_valid, and the next DRDY is serviced normally.
- reset_n asserted in the middle of a WREG frame. Required: all outputs at reset values the next cycle, and no spi_start until start_init.
